// File: rtl/enigma_pkg.sv
// enigma_pkg: shared letter type, alphabet size and controller state encoding
// for the Enigma rotor-chain sequencer.
package enigma_pkg;

  typedef logic [4:0] letter_t;

  localparam int unsigned NUM_LETTERS = 26;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STEP   = 3'd2,
    SETTLE = 3'd3,
    SAMPLE = 3'd4,
    OUT    = 3'd5
  } ctrl_state_t;

endpackage

// File: rtl/enigma_ctrl_if.sv
// enigma_ctrl_if: plaintext input and ciphertext output handshakes of the
// Enigma sequencer. master = letter source/sink, slave = enigma_ctrl.
interface enigma_ctrl_if;
  import enigma_pkg::*;

  logic    key_valid;
  letter_t key_char;
  logic    key_ready;
  logic    out_valid;
  letter_t out_char;
  logic    out_ready;

  modport master (
    output key_valid, key_char, out_ready,
    input  key_ready, out_valid, out_char
  );

  modport slave (
    input  key_valid, key_char, out_ready,
    output key_ready, out_valid, out_char
  );

endinterface

// File: rtl/enigma_step_logic.sv
// enigma_step_logic: maps rotor notch outputs to per-keystroke step pulses.
// Build option ENIGMA_CTRL_DOUBLE_STEP_EN selects the historical double-step
// rule; otherwise rotors advance like a plain odometer.
module enigma_step_logic #(
  parameter int unsigned NUM_ROTORS = 3
) (
  input  logic [NUM_ROTORS-1:0] notch,
  output logic [NUM_ROTORS-1:0] step
);

`ifdef ENIGMA_CTRL_DOUBLE_STEP_EN
  // Middle rotors step on their own notch too, giving the double-step anomaly
  always_comb begin
    step    = '0;
    step[0] = 1'b1;
    for (int unsigned i = 1; i < NUM_ROTORS - 1; i++) begin
      step[i] = notch[i-1] | notch[i];
    end
    step[NUM_ROTORS-1] = notch[NUM_ROTORS-2];
  end
`else
  // The slowest rotor's notch carries into nothing in odometer mode
  logic notch_unused;
  assign notch_unused = notch[NUM_ROTORS-1];

  // Carry ripples from the fast rotor through each notch
  always_comb begin
    step    = '0;
    step[0] = 1'b1;
    for (int unsigned i = 1; i < NUM_ROTORS; i++) begin
      step[i] = step[i-1] & notch[i-1];
    end
  end
`endif

endmodule

// File: rtl/enigma_ctrl.sv
// enigma_ctrl: character sequencer driving the Enigma rotor chain. Accepts a
// letter, steps the rotors, waits for the path to settle, returns the cipher
// letter. Build option ENIGMA_CTRL_DOUBLE_STEP_EN (see enigma_step_logic).
module enigma_ctrl
  import enigma_pkg::*;
#(
  parameter int unsigned NUM_ROTORS    = 3,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_load,
  input  logic [NUM_ROTORS-1:0][4:0]   cfg_pos,
  output logic                         cfg_ready,
  enigma_ctrl_if.slave                 kif,
  output logic                         rot_load_key,
  output logic [NUM_ROTORS-1:0][4:0]   rot_key,
  output logic [NUM_ROTORS-1:0]        rot_step,
  input  logic [NUM_ROTORS-1:0]        rot_notch,
  output letter_t                      path_char,
  input  letter_t                      path_result,
  output logic                         err_char,
  output logic [15:0]                  char_count
);

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  ctrl_state_t             state;
  logic                    live;
  logic [CW-1:0]           settle_cnt;
  letter_t                 out_char_q;
  logic [NUM_ROTORS-1:0]   step_vec;
  logic                    accept;

  enigma_step_logic #(.NUM_ROTORS(NUM_ROTORS)) u_step (
    .notch (rot_notch),
    .step  (step_vec)
  );

  // IDLE is entered during reset, but readiness is withheld until the first
  // edge after reset releases, keeping cfg_ready/key_ready low under reset.
  assign cfg_ready     = (state == IDLE) && live;
  assign kif.key_ready = cfg_ready && !cfg_load;
  assign accept        = kif.key_valid && kif.key_ready;

  assign rot_load_key  = (state == LOAD);
  assign rot_step      = (state == STEP) ? step_vec : '0;
  assign kif.out_valid = (state == OUT);
  assign kif.out_char  = out_char_q;

  // Sequencer FSM and its datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      live       <= 1'b0;
      settle_cnt <= '0;
      rot_key    <= '0;
      path_char  <= '0;
      out_char_q <= '0;
      err_char   <= 1'b0;
      char_count <= '0;
    end else begin
      live     <= 1'b1;
      err_char <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_ready && cfg_load) begin
            rot_key <= cfg_pos;
            state   <= LOAD;
          end else if (accept) begin
            if (kif.key_char > letter_t'(NUM_LETTERS - 1)) begin
              err_char <= 1'b1;
            end else begin
              path_char <= kif.key_char;
              state     <= STEP;
            end
          end
        end
        LOAD:   state <= IDLE;
        STEP: begin
          settle_cnt <= CW'(SETTLE_CYCLES - 1);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        SAMPLE: begin
          out_char_q <= path_result;
          char_count <= char_count + 16'd1;
          state      <= OUT;
        end
        OUT: begin
          if (kif.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_ctrl.sv
// tb_enigma_ctrl: directed self-checking bench for enigma_ctrl (defaults
// NUM_ROTORS=3, SETTLE_CYCLES=2).
module tb_enigma_ctrl;
  import enigma_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            cfg_load;
  logic [2:0][4:0] cfg_pos;
  logic            cfg_ready;
  logic            rot_load_key;
  logic [2:0][4:0] rot_key;
  logic [2:0]      rot_step;
  logic [2:0]      rot_notch;
  letter_t         path_char;
  letter_t         path_result;
  logic            err_char;
  logic [15:0]     char_count;

  int n_cmp  = 0;
  int n_fail = 0;

  enigma_ctrl_if kif ();

  enigma_ctrl #(.NUM_ROTORS(3), .SETTLE_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_load     (cfg_load),
    .cfg_pos      (cfg_pos),
    .cfg_ready    (cfg_ready),
    .kif          (kif),
    .rot_load_key (rot_load_key),
    .rot_key      (rot_key),
    .rot_step     (rot_step),
    .rot_notch    (rot_notch),
    .path_char    (path_char),
    .path_result  (path_result),
    .err_char     (err_char),
    .char_count   (char_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_load = 1'b0; cfg_pos = '0; rot_notch = '0;
    path_result = '0; kif.key_valid = 1'b0; kif.key_char = '0; kif.out_ready = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if ({cfg_ready, kif.key_ready, rot_load_key, rot_step, kif.out_valid, err_char} !== 8'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0",
        {cfg_ready, kif.key_ready, rot_load_key, rot_step, kif.out_valid, err_char});
    end
    n_cmp++; if ({rot_key, path_char, kif.out_char, char_count} !== 41'd0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {rot_key, path_char, kif.out_char, char_count});
    end
    reset = 1'b0;
    tick();
    n_cmp++; if (kif.key_ready !== 1'b1 || cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: got %b%b expected 11", kif.key_ready, cfg_ready);
    end
  endtask

  task automatic test_load();
    cfg_pos = {5'd5, 5'd3, 5'd0};
    cfg_load = 1'b1;
    kif.key_valid = 1'b1; kif.key_char = 5'd2;
    #1;
    n_cmp++; if (kif.key_ready !== 1'b0) begin
      n_fail++; $display("FAIL key_ready_cfg_prio: got %b expected 0", kif.key_ready);
    end
    tick();
    cfg_load = 1'b0; kif.key_valid = 1'b0;
    n_cmp++; if (rot_load_key !== 1'b1 || rot_key !== {5'd5, 5'd3, 5'd0}) begin
      n_fail++; $display("FAIL load_pulse: got %b/%h expected 1/%h", rot_load_key, rot_key, {5'd5, 5'd3, 5'd0});
    end
    n_cmp++; if (kif.key_ready !== 1'b0 || cfg_ready !== 1'b0 || rot_step !== 3'b000) begin
      n_fail++; $display("FAIL load_busy: got kr=%b cr=%b step=%b expected 0 0 000", kif.key_ready, cfg_ready, rot_step);
    end
    tick();
    n_cmp++; if (rot_load_key !== 1'b0 || cfg_ready !== 1'b1 || rot_key !== {5'd5, 5'd3, 5'd0}) begin
      n_fail++; $display("FAIL load_done: got lk=%b cr=%b key=%h expected 0 1 %h", rot_load_key, cfg_ready, rot_key, {5'd5, 5'd3, 5'd0});
    end
  endtask

  // Full letter with out_ready high: accept edge, step in cycle 1, valid in cycle 5
  task automatic run_char(input letter_t ch, input logic [2:0] notch, input letter_t res,
                          input logic [2:0] exp_step, input logic [15:0] exp_cnt);
    kif.key_valid = 1'b1; kif.key_char = ch; rot_notch = notch; path_result = res;
    kif.out_ready = 1'b1;
    tick();
    kif.key_valid = 1'b0;
    n_cmp++; if (rot_step !== exp_step || path_char !== ch) begin
      n_fail++; $display("FAIL step_c1: got step=%b pc=%0d expected %b %0d", rot_step, path_char, exp_step, ch);
    end
    tick();
    n_cmp++; if (rot_step !== 3'b000) begin
      n_fail++; $display("FAIL step_c2: got %b expected 000", rot_step);
    end
    tick(); tick();
    n_cmp++; if (kif.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL valid_c4: got %b expected 0", kif.out_valid);
    end
    tick();
    n_cmp++; if (kif.out_valid !== 1'b1 || kif.out_char !== res || char_count !== exp_cnt) begin
      n_fail++; $display("FAIL out_c5: got v=%b c=%0d n=%0d expected 1 %0d %0d",
        kif.out_valid, kif.out_char, char_count, res, exp_cnt);
    end
    tick();
    n_cmp++; if (kif.out_valid !== 1'b0 || kif.key_ready !== 1'b1) begin
      n_fail++; $display("FAIL back_idle: got v=%b kr=%b expected 0 1", kif.out_valid, kif.key_ready);
    end
  endtask

  task automatic test_encipher();
    run_char(5'd0, 3'b000, 5'd7, 3'b001, 16'd1);
  endtask

  task automatic test_stepping();
    run_char(5'd1, 3'b001, 5'd9, 3'b011, 16'd2);
`ifdef ENIGMA_CTRL_DOUBLE_STEP_EN
    run_char(5'd2, 3'b010, 5'd11, 3'b111, 16'd3);
`else
    run_char(5'd2, 3'b010, 5'd11, 3'b001, 16'd3);
`endif
    run_char(5'd3, 3'b011, 5'd12, 3'b111, 16'd4);
    run_char(5'd25, 3'b100, 5'd13, 3'b001, 16'd5);
  endtask

  task automatic test_stall();
    kif.key_valid = 1'b1; kif.key_char = 5'd4; rot_notch = 3'b000; path_result = 5'd20;
    kif.out_ready = 1'b0;
    tick();
    kif.key_valid = 1'b0;
    tick(); tick(); tick(); tick();
    path_result = 5'd21;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (kif.out_valid !== 1'b1 || kif.out_char !== 5'd20 || kif.key_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_%0d: got v=%b c=%0d kr=%b expected 1 20 0",
          i, kif.out_valid, kif.out_char, kif.key_ready);
      end
      kif.key_valid = (i == 1); kif.key_char = 5'd6;
      tick();
    end
    kif.key_valid = 1'b0;
    kif.out_ready = 1'b1;
    tick();
    n_cmp++; if (kif.out_valid !== 1'b0 || path_char !== 5'd4 || char_count !== 16'd6) begin
      n_fail++; $display("FAIL stall_release: got v=%b pc=%0d n=%0d expected 0 4 6",
        kif.out_valid, path_char, char_count);
    end
  endtask

  task automatic test_err_reset();
    kif.key_valid = 1'b1; kif.key_char = 5'd27; rot_notch = 3'b001;
    tick();
    kif.key_valid = 1'b0;
    n_cmp++; if (err_char !== 1'b1 || rot_step !== 3'b000 || kif.key_ready !== 1'b1) begin
      n_fail++; $display("FAIL err_pulse: got e=%b step=%b kr=%b expected 1 000 1", err_char, rot_step, kif.key_ready);
    end
    tick();
    n_cmp++; if (err_char !== 1'b0 || rot_step !== 3'b000 || char_count !== 16'd6) begin
      n_fail++; $display("FAIL err_after: got e=%b step=%b n=%0d expected 0 000 6", err_char, rot_step, char_count);
    end
    kif.key_valid = 1'b1; kif.key_char = 5'd8;
    tick();
    kif.key_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (kif.out_valid !== 1'b0 || cfg_ready !== 1'b0 || path_char !== 5'd0 || char_count !== 16'd0) begin
      n_fail++; $display("FAIL mid_reset: got v=%b cr=%b pc=%0d n=%0d expected 0 0 0 0",
        kif.out_valid, cfg_ready, path_char, char_count);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (kif.out_valid !== 1'b0 || kif.key_ready !== 1'b1) begin
        n_fail++; $display("FAIL post_reset_%0d: got v=%b kr=%b expected 0 1", i, kif.out_valid, kif.key_ready);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load();
    test_encipher();
    test_stepping();
    test_stall();
    test_err_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
